// File: rtl/gated_click_counter.sv
`default_nettype none
// ============================================================================
// gated_click_counter: counts detector clicks inside/outside the detection gate
// over N sync periods and measures the sync period; results leave via
// valid/ready.  Optional click dead time: GATED_CLICK_DEADTIME_EN.   Rev 1.0
// ============================================================================
module gated_click_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int GATE_ALIGN  = 3,
  parameter int DEADTIME    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sync_in,
  input  logic        det_gate,
  input  logic        click,
  input  logic [31:0] accum_periods,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] in_gate_count,
  output logic [31:0] out_gate_count,
  output logic [31:0] period_cycles,
  output logic        overrun,
  input  logic        clr_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  localparam logic [31:0] C_SAT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == C_SAT_MAX) ? v : v + 32'd1;
  endfunction

  logic [SYNC_STAGES-1:0] click_sync_q, click_sync_d;
  logic                   click_prev_q, click_prev_d;
  logic                   click_p_q, click_p_d;
  logic [GATE_ALIGN-1:0]  gate_dly_q, gate_dly_d;
  logic                   sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   gate_a, sync_p;

  state_t      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] periods_done_q, periods_done_d;
  logic [31:0] acc_in_q, acc_in_d;
  logic [31:0] acc_out_q, acc_out_d;

  logic        result_valid_q, result_valid_d;
  logic [31:0] in_cnt_q, in_cnt_d;
  logic [31:0] out_cnt_q, out_cnt_d;
  logic [31:0] period_q, period_d;
  logic        overrun_q, overrun_d;

  logic        click_cnt, click_in, click_out;
  logic [31:0] in_nx, out_nx;
  logic        publish, xfer, drop;
  logic [31:0] pub_in, pub_out, pub_period;

  generate
    if (GATE_ALIGN > 1) begin : g_gate_shift
      assign gate_dly_d = {gate_dly_q[GATE_ALIGN-2:0], det_gate};
    end else begin : g_gate_single
      assign gate_dly_d = det_gate;
    end
  endgenerate

  always_comb begin
    click_sync_d = {click_sync_q[SYNC_STAGES-2:0], click};
    click_prev_d = click_sync_q[SYNC_STAGES-1];
    // Registered edge pulse: lands GATE_ALIGN cycles after the click is first sampled.
    click_p_d    = click_sync_q[SYNC_STAGES-1] & ~click_prev_q;
    sync_d       = sync_in;
    sync_prev_d  = sync_q;
  end

  assign gate_a = gate_dly_q[GATE_ALIGN-1];
  assign sync_p = sync_q & ~sync_prev_q;

`ifdef GATED_CLICK_DEADTIME_EN
  logic [31:0] dead_q, dead_d;
  assign click_cnt = click_p_q & (dead_q == 32'd0);

  always_comb begin
    dead_d = (dead_q != 32'd0) ? dead_q - 32'd1 : 32'd0;
    if (state_q == ST_ACCUM && enable && click_cnt) begin
      dead_d = 32'(DEADTIME);
    end
    if (state_q == ST_IDLE) begin
      dead_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dead_q <= 32'd0;
    else        dead_q <= dead_d;
  end
`else
  logic unused_deadtime;
  assign unused_deadtime = ^32'(DEADTIME);
  assign click_cnt       = click_p_q;
`endif

  assign click_in  = click_cnt & gate_a;
  assign click_out = click_cnt & ~gate_a;
  assign in_nx     = click_in  ? sat_inc(acc_in_q)  : acc_in_q;
  assign out_nx    = click_out ? sat_inc(acc_out_q) : acc_out_q;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    period_cnt_d   = period_cnt_q;
    periods_done_d = periods_done_q;
    acc_in_d       = acc_in_q;
    acc_out_d      = acc_out_q;
    publish        = 1'b0;
    pub_in         = in_nx;
    pub_out        = out_nx;
    pub_period     = period_cnt_q;

    case (state_q)
      ST_IDLE: begin
        period_cnt_d   = 32'd0;
        periods_done_d = 32'd0;
        acc_in_d       = 32'd0;
        acc_out_d      = 32'd0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        n_d = (accum_periods == 32'd0) ? 32'd1 : accum_periods;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sync_p) begin
          // The ARM exit edge is itself a sync edge, so the count restarts at 1.
          state_d        = ST_ACCUM;
          period_cnt_d   = 32'd1;
          periods_done_d = 32'd0;
          acc_in_d       = 32'd0;
          acc_out_d      = 32'd0;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d        = ST_IDLE;
          period_cnt_d   = 32'd0;
          periods_done_d = 32'd0;
          acc_in_d       = 32'd0;
          acc_out_d      = 32'd0;
        end else if (sync_p) begin
          period_cnt_d = 32'd1;
          if (periods_done_q + 32'd1 == n_q) begin
            publish        = 1'b1;
            periods_done_d = 32'd0;
            acc_in_d       = 32'd0;
            acc_out_d      = 32'd0;
          end else begin
            periods_done_d = periods_done_q + 32'd1;
            acc_in_d       = in_nx;
            acc_out_d      = out_nx;
          end
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
          acc_in_d     = in_nx;
          acc_out_d    = out_nx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result_valid_d = result_valid_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    period_d       = period_q;
    drop           = 1'b0;
    xfer           = result_valid_q & result_ready;
    if (publish && (!result_valid_q || xfer)) begin
      result_valid_d = 1'b1;
      in_cnt_d       = pub_in;
      out_cnt_d      = pub_out;
      period_d       = pub_period;
    end else if (publish) begin
      drop = 1'b1;
    end else if (xfer) begin
      result_valid_d = 1'b0;
    end
    overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      click_sync_q   <= '0;
      click_prev_q   <= 1'b0;
      click_p_q      <= 1'b0;
      gate_dly_q     <= '0;
      sync_q         <= 1'b0;
      sync_prev_q    <= 1'b0;
      state_q        <= ST_IDLE;
      n_q            <= 32'd0;
      period_cnt_q   <= 32'd0;
      periods_done_q <= 32'd0;
      acc_in_q       <= 32'd0;
      acc_out_q      <= 32'd0;
      result_valid_q <= 1'b0;
      in_cnt_q       <= 32'd0;
      out_cnt_q      <= 32'd0;
      period_q       <= 32'd0;
      overrun_q      <= 1'b0;
    end else begin
      click_sync_q   <= click_sync_d;
      click_prev_q   <= click_prev_d;
      click_p_q      <= click_p_d;
      gate_dly_q     <= gate_dly_d;
      sync_q         <= sync_d;
      sync_prev_q    <= sync_prev_d;
      state_q        <= state_d;
      n_q            <= n_d;
      period_cnt_q   <= period_cnt_d;
      periods_done_q <= periods_done_d;
      acc_in_q       <= acc_in_d;
      acc_out_q      <= acc_out_d;
      result_valid_q <= result_valid_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      period_q       <= period_d;
      overrun_q      <= overrun_d;
    end
  end

  assign result_valid   = result_valid_q;
  assign in_gate_count  = in_cnt_q;
  assign out_gate_count = out_cnt_q;
  assign period_cycles  = period_q;
  assign overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gated_click_counter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for gated_click_counter: timestamp-based reference model feeding a
// result scoreboard; a negedge monitor checks every presented result.
module tb_gated_click_counter;

  localparam int TB_DEADTIME = 16;

  logic        clk = 1'b0;
  logic        rst_n, enable, sync_in, det_gate, click, result_ready, clr_overrun;
  logic [31:0] accum_periods;
  logic        result_valid, overrun;
  logic [31:0] in_gate_count, out_gate_count, period_cycles;

  always #5 clk = ~clk;

  gated_click_counter #(
    .SYNC_STAGES(2), .GATE_ALIGN(3), .DEADTIME(TB_DEADTIME)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync_in(sync_in),
    .det_gate(det_gate), .click(click), .accum_periods(accum_periods),
    .result_valid(result_valid), .result_ready(result_ready),
    .in_gate_count(in_gate_count), .out_gate_count(out_gate_count),
    .period_cycles(period_cycles), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int unsigned in_c; int unsigned out_c; int unsigned per; } res_t;
  typedef struct { longint t; bit in_g; } cev_t;

  res_t exp_q[$];
  cev_t click_evq[$];

  // Reference model: events are timestamped by edge index; a click counts at
  // its sample edge + 3 with the gate value seen at its sample edge, a sync
  // rise acts one edge after it is sampled.
  longint      k = 0;
  longint      sync_ev = -1;
  bit          prev_sync_smp = 0, prev_click_smp = 0;
  int          mstate = 0;  // 0 idle, 1 armed, 2 accumulating
  int unsigned m_n = 1, m_periods = 0, m_in = 0, m_out = 0;
  longint      m_last_sync = 0, m_last_count = -1000000;
  bit          m_valid = 0, m_ovr = 0;
  bit          m_sp, m_cp, m_cg, m_pub, m_xfer, m_drop;
  res_t        m_r;
  cev_t        m_ev;

  always @(posedge clk) begin
    k++;
    if (!rst_n) begin
      mstate = 0; m_valid = 0; m_ovr = 0; sync_ev = -1;
      prev_sync_smp = 0; prev_click_smp = 0; m_last_count = -1000000;
      exp_q.delete(); click_evq.delete();
    end else begin
      m_sp = (sync_ev == k);
      m_cp = 0; m_cg = 0;
      if (click_evq.size() > 0 && click_evq[0].t == k) begin
        m_cp = 1; m_cg = click_evq[0].in_g;
        void'(click_evq.pop_front());
      end
      if (sync_in && !prev_sync_smp) sync_ev = k + 1;
      if (click && !prev_click_smp) begin
        m_ev.t = k + 3; m_ev.in_g = det_gate;
        click_evq.push_back(m_ev);
      end
      prev_sync_smp = sync_in; prev_click_smp = click;

      m_pub = 0;
      case (mstate)
        0: begin
          m_last_count = -1000000;
          if (enable) mstate = 1;
        end
        1: begin
          m_n = (accum_periods == 0) ? 1 : accum_periods;
          if (!enable) mstate = 0;
          else if (m_sp) begin
            mstate = 2; m_last_sync = k; m_periods = 0; m_in = 0; m_out = 0;
          end
        end
        default: begin
          if (!enable) mstate = 0;
          else begin
            if (m_cp) begin
`ifdef GATED_CLICK_DEADTIME_EN
              if (k - m_last_count <= TB_DEADTIME) m_cp = 0;
              else m_last_count = k;
`endif
              if (m_cp) begin
                if (m_cg) m_in++; else m_out++;
              end
            end
            if (m_sp) begin
              m_r.per = int'(k - m_last_sync);
              m_last_sync = k;
              m_periods++;
              if (m_periods == m_n) begin
                m_pub = 1; m_r.in_c = m_in; m_r.out_c = m_out;
                m_periods = 0; m_in = 0; m_out = 0;
              end
            end
          end
        end
      endcase

      m_xfer = m_valid && result_ready;
      m_drop = 0;
      if (m_pub && (!m_valid || m_xfer)) begin
        m_valid = 1; exp_q.push_back(m_r);
      end else if (m_pub) begin
        m_drop = 1;
      end else if (m_xfer) begin
        m_valid = 0;
      end
      if (m_drop) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
    end
  end

  // Monitor / scoreboard
  int          n_xfer = 0;
  logic [31:0] last_in = 0, last_out = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (result_valid !== m_valid) begin
        errors++; $display("FAIL result_valid: got %b want %b at %0t", result_valid, m_valid, $time);
      end
      checks++;
      if (overrun !== m_ovr) begin
        errors++; $display("FAIL overrun: got %b want %b at %0t", overrun, m_ovr, $time);
      end
      if (result_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL result: valid with no expected result at %0t", $time);
        end else begin
          if (in_gate_count !== exp_q[0].in_c || out_gate_count !== exp_q[0].out_c ||
              period_cycles !== exp_q[0].per) begin
            errors++;
            $display("FAIL result: got in=%0d out=%0d per=%0d want in=%0d out=%0d per=%0d at %0t",
                     in_gate_count, out_gate_count, period_cycles,
                     exp_q[0].in_c, exp_q[0].out_c, exp_q[0].per, $time);
          end
          if (result_ready === 1'b1) begin
            last_in = in_gate_count; last_out = out_gate_count;
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Stimulus
  int ph = 0, cfg_per = 100, cfg_glo = 20, cfg_ghi = 29;
  int cfg_click_mode = 1, cfg_ready_mode = 0, cfg_clr_mode = 0;
  int clk_ph[$];

  task automatic run(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      ph = (ph + 1) % cfg_per;
      sync_in = (ph < cfg_per / 2);
      if (cfg_click_mode == 2) begin
        det_gate = 1'($urandom_range(0, 1));
        click    = ($urandom_range(0, 2) == 0);
      end else begin
        det_gate = (ph >= cfg_glo && ph <= cfg_ghi);
        click = 1'b0;
        foreach (clk_ph[j]) if (clk_ph[j] == ph) click = 1'b1;
      end
      case (cfg_ready_mode)
        0:       result_ready = 1'b1;
        1:       result_ready = 1'b0;
        default: result_ready = 1'($urandom_range(0, 1));
      endcase
      case (cfg_clr_mode)
        0:       clr_overrun = 1'b0;
        1:       clr_overrun = ($urandom_range(0, 7) == 0);
        default: clr_overrun = 1'b1;
      endcase
    end
  endtask

  task automatic rearm(input int unsigned n);
    enable = 1'b0; run(3);
    accum_periods = n; ph = cfg_per - 1; enable = 1'b1;
  endtask

  int x0;

  initial begin
    rst_n = 1'b0; enable = 1'b0; sync_in = 1'b0; det_gate = 1'b0; click = 1'b0;
    result_ready = 1'b0; clr_overrun = 1'b0; accum_periods = 32'd0;
    repeat (2) begin
      @(posedge clk); #1;
      enable = 1'($urandom_range(0, 1)); sync_in = 1'($urandom_range(0, 1));
      det_gate = 1'($urandom_range(0, 1)); click = 1'($urandom_range(0, 1));
      result_ready = 1'($urandom_range(0, 1)); clr_overrun = 1'($urandom_range(0, 1));
      accum_periods = $urandom;
    end
    @(negedge clk);
    check("reset result_valid", {31'd0, result_valid}, 0);
    check("reset overrun", {31'd0, overrun}, 0);
    check("reset in_gate_count", in_gate_count, 0);
    check("reset out_gate_count", out_gate_count, 0);
    check("reset period_cycles", period_cycles, 0);

    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1; sync_in = 1'b0; click = 1'b0; det_gate = 1'b0;
    result_ready = 1'b1; clr_overrun = 1'b0; accum_periods = 32'd1;
    cfg_per = 100; ph = 99; clk_ph = {};

    // Sync period only
    x0 = n_xfer;
    run(560);
    check("period results seen", (n_xfer - x0 >= 4) ? 32'd1 : 32'd0, 1);

    // Gate classification: one in-gate and two out-of-gate clicks per period
    clk_ph = {22, 50, 70};
    rearm(4);
    x0 = n_xfer;
    run(1000);
    check("gate results seen", (n_xfer - x0 >= 1) ? 32'd1 : 32'd0, 1);
    check("gate in_gate_count", last_in, 4);
    check("gate out_gate_count", last_out, 8);

    // Boundary click coinciding with sync_p
    clk_ph = {98};
    rearm(1);
    run(600);
    check("boundary in_gate_count", last_in, 0);
    check("boundary out_gate_count", last_out, 1);

    // Backpressure across several publishes
    clk_ph = {};
    cfg_ready_mode = 1;
    rearm(1);
    run(350);
    check("bp overrun set", {31'd0, overrun}, 1);
    check("bp result held", {31'd0, result_valid}, 1);
    cfg_clr_mode = 2; run(1);
    cfg_clr_mode = 0; run(1);
    check("bp overrun cleared", {31'd0, overrun}, 0);
    cfg_ready_mode = 0; run(1);
    check("bp valid before accept", {31'd0, result_valid}, 1);
    run(1);
    check("bp valid after accept", {31'd0, result_valid}, 0);

    // Dead time: four in-gate clicks five cycles apart
    cfg_glo = 20; cfg_ghi = 45;
    clk_ph = {22, 27, 32, 37};
    rearm(1);
    run(500);
`ifndef GATED_CLICK_DEADTIME_EN
    check("deadtime-off in_gate_count", last_in, 4);
`endif

    // Randomized traffic with enable drops and accum changes
    cfg_click_mode = 2; cfg_ready_mode = 2; cfg_clr_mode = 1;
    for (int s = 0; s < 6; s++) begin
      cfg_per = $urandom_range(12, 40);
      rearm($urandom_range(0, 3));
      run(200);
      accum_periods = $urandom_range(0, 3);
      run(200);
    end
    cfg_ready_mode = 0; cfg_clr_mode = 0;
    enable = 1'b0;
    run(5);
    check("final valid drained", {31'd0, result_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
